// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and constants for the data cache controller
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE
    } state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [31:0] DEADBEEF = 32'hDEADBEEF;

    // funct3 encodings 011, 110 and 111 have no load/store meaning
    function automatic logic f3_supported(input logic [2:0] f3);
        return !((f3 == 3'b011) || (f3[2:1] == 2'b11));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane load extraction and store merge for one 32-bit word
module mem_lane_align
    import dcache_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic        merge,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] loaded;
    logic [31:0] merged;

    // Pick the addressed lane and extend it, or merge store bytes into the word
    always_comb begin
        lane_b = word[{offset, 3'b000} +: 8];
        lane_h = word[{offset[1], 4'b0000} +: 16];
        case (funct3)
            LB:      loaded = {{24{lane_b[7]}}, lane_b};
            LBU:     loaded = {24'b0, lane_b};
            LH:      loaded = {{16{lane_h[15]}}, lane_h};
            LHU:     loaded = {16'b0, lane_h};
            default: loaded = word;
        endcase
        merged = word;
        case ({1'b0, funct3[1:0]})
            SB:      merged[{offset, 3'b000} +: 8] = wdata[7:0];
            SH:      merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            SW:      merged = wdata;
            default: merged = word;
        endcase
        result = merge ? merged : loaded;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through no-write-allocate data cache controller
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SETS          = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] a,
    input  logic                     re,
    input  logic                     we,
    input  logic [DATA_WIDTH-1:0]    writedata,
    input  logic [2:0]               memcontrol,
    output logic [DATA_WIDTH-1:0]    readdata,
    output logic                     stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic [2:0]               mem_ctrl,
    input  logic                     mem_ack,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDRESS_WIDTH - IDX_W - 2;

    state_t                     state;
    logic [SETS-1:0]            valid;
    logic [TAG_W-1:0]           tag_arr  [SETS];
    logic [DATA_WIDTH-1:0]      data_arr [SETS];

    logic [IDX_W-1:0]           idx;
    logic [TAG_W-1:0]           tag;
    logic [IDX_W-1:0]           m_idx;
    logic [TAG_W-1:0]           m_tag;
    logic                       hit;
    logic                       m_hit;
    logic                       supported;
    logic [DATA_WIDTH-1:0]      load_data;
    logic [DATA_WIDTH-1:0]      merged_word;
    logic [ADDRESS_WIDTH-1:0]   st_addr;

    // The latched mem_addr doubles as the index/tag/lane of the in-flight transaction
    assign idx       = a[IDX_W+1:2];
    assign tag       = a[ADDRESS_WIDTH-1:IDX_W+2];
    assign m_idx     = mem_addr[IDX_W+1:2];
    assign m_tag     = mem_addr[ADDRESS_WIDTH-1:IDX_W+2];
    assign hit       = valid[idx] && (tag_arr[idx] == tag);
    assign m_hit     = valid[m_idx] && (tag_arr[m_idx] == m_tag);
    assign supported = f3_supported(memcontrol);

    mem_lane_align u_rd_align (
        .word   (data_arr[idx]),
        .wdata  ('0),
        .offset (a[1:0]),
        .funct3 (memcontrol),
        .merge  (1'b0),
        .result (load_data)
    );

    mem_lane_align u_wr_align (
        .word   (data_arr[m_idx]),
        .wdata  (mem_wdata),
        .offset (mem_addr[1:0]),
        .funct3 (mem_ctrl),
        .merge  (1'b1),
        .result (merged_word)
    );

    // Store address forced to its natural alignment; byte stores keep the lane
    always_comb begin
        st_addr = a;
        case (memcontrol[1:0])
            2'b01:   st_addr[0]   = 1'b0;
            2'b10:   st_addr[1:0] = 2'b00;
            default: st_addr      = a;
        endcase
    end

    // Load result and pipeline stall are combinational so hits cost no cycles
    always_comb begin
        readdata = supported ? load_data : DEADBEEF;
        stall    = 1'b0;
        case (state)
            IDLE:    stall = supported && (we || (re && !hit));
            FILL:    stall = 1'b1;
            WRITE:   stall = !mem_ack;
            default: stall = 1'b0;
        endcase
    end

    // Controller FSM: issues fills and write-throughs, owns valid bits and mem_* outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            valid     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_ctrl  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (supported && we) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= st_addr;
                        mem_wdata <= writedata;
                        mem_ctrl  <= memcontrol;
                        state     <= WRITE;
                    end else if (supported && re && !hit) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {a[ADDRESS_WIDTH-1:2], 2'b00};
                        mem_ctrl <= LW;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        mem_req      <= 1'b0;
                        valid[m_idx] <= 1'b1;
                        state        <= IDLE;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line storage: fill on load-miss completion, merge on write-through hit
    always_ff @(posedge clk) begin
        if ((state == FILL) && mem_ack) begin
            tag_arr[m_idx]  <= m_tag;
            data_arr[m_idx] <= mem_rdata;
        end else if ((state == WRITE) && mem_ack && m_hit) begin
            data_arr[m_idx] <= merged_word;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - scoreboard bench for dcache_ctrl
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic        re;
    logic        we;
    logic [31:0] writedata;
    logic [2:0]  memcontrol;
    logic [31:0] readdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_ctrl;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    dcache_ctrl #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .SETS(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .re         (re),
        .we         (we),
        .writedata  (writedata),
        .memcontrol (memcontrol),
        .readdata   (readdata),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ctrl   (mem_ctrl),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        re;
        logic        we;
        logic [31:0] a;
        logic [31:0] wdata;
        logic [2:0]  f3;
        int          lat;
        logic        chk_rd;
        logic [31:0] rd;
        int          stalls;
        logic        has_mem;
        logic        mwe;
        logic [31:0] maddr;
        logic [2:0]  mctrl;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [2:0]  ctrl;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic        chk_rd;
        logic [31:0] rd;
        int          stalls;
    } ret_exp_t;

    mem_exp_t exp_mem[$];
    ret_exp_t exp_ret[$];
    vec_t     vecs[$];

    int n_vec = 0;
    int n_bad = 0;
    int mem_lat = 3;
    int stall_cnt = 0;
    logic op_active = 1'b0;
    logic op_done = 1'b0;

    bit [31:0] mem_words [bit [31:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic bit [31:0] rd_mem(input bit [31:0] wa);
        if (mem_words.exists(wa)) return mem_words[wa];
        return 32'h0;
    endfunction

    // Memory model: acks L cycles after the first mem_req cycle, keeps going through resets
    initial begin
        logic        busy;
        int          cnt;
        logic [31:0] t_addr;
        logic [31:0] t_wd;
        logic [2:0]  t_ctrl;
        logic        t_we;
        bit   [31:0] w;
        busy = 1'b0;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (busy) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    w = rd_mem({t_addr[31:2], 2'b00});
                    if (t_we) begin
                        case (t_ctrl[1:0])
                            2'b00:   w[8*int'(t_addr[1:0]) +: 8] = t_wd[7:0];
                            2'b01:   w[16*int'(t_addr[1]) +: 16] = t_wd[15:0];
                            default: w = t_wd;
                        endcase
                        mem_words[{t_addr[31:2], 2'b00}] = w;
                        mem_rdata = 32'h0;
                    end else begin
                        mem_rdata = w;
                    end
                    mem_ack = 1'b1;
                    busy = 1'b0;
                end
            end else if (mem_req) begin
                busy = 1'b1;
                cnt = 0;
                t_addr = mem_addr;
                t_wd = mem_wdata;
                t_ctrl = mem_ctrl;
                t_we = mem_we;
            end
        end
    end

    // Transaction monitor: each rising mem_req is compared with the next expected transaction
    initial begin
        logic seen;
        mem_exp_t e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req && !seen) begin
                seen = 1'b1;
                if (exp_mem.size() == 0) begin
                    chk("unexpected_mem_req", mem_addr, 32'hFFFFFFFF);
                end else begin
                    e = exp_mem.pop_front();
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
                    chk("mem_ctrl", {29'b0, mem_ctrl}, {29'b0, e.ctrl});
                    if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                end
            end
            if (!mem_req) seen = 1'b0;
        end
    end

    // Retire monitor: counts stall cycles and checks the result when the op completes
    initial begin
        ret_exp_t r;
        forever begin
            @(negedge clk);
            if (op_active && !op_done) begin
                if (stall) begin
                    stall_cnt++;
                end else begin
                    if (exp_ret.size() == 0) begin
                        chk("unexpected_retire", 32'h0, 32'h1);
                    end else begin
                        r = exp_ret.pop_front();
                        if (r.chk_rd) chk("readdata", readdata, r.rd);
                        chk("stall_cycles", stall_cnt, r.stalls);
                    end
                    op_done = 1'b1;
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        bit ok;
        mem_lat = v.lat;
        if (v.has_mem) exp_mem.push_back('{addr: v.maddr, we: v.mwe, ctrl: v.mctrl, wdata: v.wdata});
        exp_ret.push_back('{chk_rd: v.chk_rd, rd: v.rd, stalls: v.stalls});
        a = v.a;
        re = v.re;
        we = v.we;
        writedata = v.wdata;
        memcontrol = v.f3;
        stall_cnt = 0;
        op_done = 1'b0;
        op_active = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (op_done) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        op_active = 1'b0;
        re = 1'b0;
        we = 1'b0;
        if (!ok) begin
            chk("retire_timeout", 32'h0, 32'h1);
            exp_ret.delete();
        end
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        a = '0;
        re = 1'b0;
        we = 1'b0;
        writedata = '0;
        memcontrol = 3'b010;
        mem_words[32'h00010000] = 32'h11223344;
        mem_words[32'h00010400] = 32'h55AA55AA;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_ctrl", {29'b0, mem_ctrl}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        //                 re    we    a             wdata         f3      L  chk   rd            st has   mwe   maddr         mctrl
        vecs.push_back('{1'b1, 1'b0, 32'h00010000, 32'h00000000, 3'b010, 3, 1'b1, 32'h11223344, 5, 1'b1, 1'b0, 32'h00010000, 3'b010});
        vecs.push_back('{1'b1, 1'b0, 32'h00010000, 32'h00000000, 3'b010, 3, 1'b1, 32'h11223344, 0, 1'b0, 1'b0, 32'h00000000, 3'b000});
        vecs.push_back('{1'b0, 1'b1, 32'h00010001, 32'h123456AB, 3'b000, 3, 1'b0, 32'h00000000, 4, 1'b1, 1'b1, 32'h00010001, 3'b000});
        vecs.push_back('{1'b1, 1'b0, 32'h00010000, 32'h00000000, 3'b010, 3, 1'b1, 32'h1122AB44, 0, 1'b0, 1'b0, 32'h00000000, 3'b000});
        vecs.push_back('{1'b0, 1'b1, 32'h00010000, 32'h000000C4, 3'b000, 1, 1'b0, 32'h00000000, 2, 1'b1, 1'b1, 32'h00010000, 3'b000});
        vecs.push_back('{1'b1, 1'b0, 32'h00010000, 32'h00000000, 3'b000, 1, 1'b1, 32'hFFFFFFC4, 0, 1'b0, 1'b0, 32'h00000000, 3'b000});
        vecs.push_back('{1'b1, 1'b0, 32'h00010000, 32'h00000000, 3'b100, 1, 1'b1, 32'h000000C4, 0, 1'b0, 1'b0, 32'h00000000, 3'b000});
        vecs.push_back('{1'b1, 1'b0, 32'h00010003, 32'h00000000, 3'b000, 1, 1'b1, 32'h00000011, 0, 1'b0, 1'b0, 32'h00000000, 3'b000});
        vecs.push_back('{1'b1, 1'b0, 32'h00010002, 32'h00000000, 3'b001, 1, 1'b1, 32'h00001122, 0, 1'b0, 1'b0, 32'h00000000, 3'b000});
        vecs.push_back('{1'b0, 1'b1, 32'h00010000, 32'h000080FF, 3'b001, 2, 1'b0, 32'h00000000, 3, 1'b1, 1'b1, 32'h00010000, 3'b001});
        vecs.push_back('{1'b1, 1'b0, 32'h00010000, 32'h00000000, 3'b101, 2, 1'b1, 32'h000080FF, 0, 1'b0, 1'b0, 32'h00000000, 3'b000});
        vecs.push_back('{1'b1, 1'b0, 32'h00010000, 32'h00000000, 3'b001, 2, 1'b1, 32'hFFFF80FF, 0, 1'b0, 1'b0, 32'h00000000, 3'b000});
        vecs.push_back('{1'b0, 1'b1, 32'h00010003, 32'h00005566, 3'b001, 1, 1'b0, 32'h00000000, 2, 1'b1, 1'b1, 32'h00010002, 3'b001});
        vecs.push_back('{1'b1, 1'b0, 32'h00010002, 32'h00000000, 3'b010, 1, 1'b1, 32'h556680FF, 0, 1'b0, 1'b0, 32'h00000000, 3'b000});
        vecs.push_back('{1'b0, 1'b1, 32'h00020000, 32'hCAFEF00D, 3'b010, 2, 1'b0, 32'h00000000, 3, 1'b1, 1'b1, 32'h00020000, 3'b010});
        vecs.push_back('{1'b1, 1'b0, 32'h00010000, 32'h00000000, 3'b010, 2, 1'b1, 32'h556680FF, 0, 1'b0, 1'b0, 32'h00000000, 3'b000});
        vecs.push_back('{1'b1, 1'b0, 32'h00020000, 32'h00000000, 3'b010, 1, 1'b1, 32'hCAFEF00D, 3, 1'b1, 1'b0, 32'h00020000, 3'b010});
        vecs.push_back('{1'b1, 1'b0, 32'h00010400, 32'h00000000, 3'b010, 2, 1'b1, 32'h55AA55AA, 4, 1'b1, 1'b0, 32'h00010400, 3'b010});
        vecs.push_back('{1'b1, 1'b0, 32'h00010000, 32'h00000000, 3'b010, 3, 1'b1, 32'h556680FF, 5, 1'b1, 1'b0, 32'h00010000, 3'b010});
        vecs.push_back('{1'b1, 1'b0, 32'h00010000, 32'h00000000, 3'b011, 3, 1'b1, 32'hDEADBEEF, 0, 1'b0, 1'b0, 32'h00000000, 3'b000});
        vecs.push_back('{1'b0, 1'b1, 32'h00010000, 32'h00000001, 3'b111, 3, 1'b1, 32'hDEADBEEF, 0, 1'b0, 1'b0, 32'h00000000, 3'b000});
        vecs.push_back('{1'b1, 1'b0, 32'h00010000, 32'h00000000, 3'b010, 3, 1'b1, 32'h556680FF, 0, 1'b0, 1'b0, 32'h00000000, 3'b000});
        vecs.push_back('{1'b1, 1'b1, 32'h00020004, 32'h01020304, 3'b010, 1, 1'b0, 32'h00000000, 2, 1'b1, 1'b1, 32'h00020004, 3'b010});
        vecs.push_back('{1'b1, 1'b0, 32'h00020007, 32'h00000000, 3'b100, 1, 1'b1, 32'h00000001, 3, 1'b1, 1'b0, 32'h00020004, 3'b010});

        foreach (vecs[i]) run_vec(vecs[i]);

        // Abort a fill with reset; the late ack must be ignored and the cache left empty
        mem_lat = 3;
        exp_mem.push_back('{addr: 32'h00030000, we: 1'b0, ctrl: 3'b010, wdata: 32'h0});
        a = 32'h00030000;
        re = 1'b1;
        memcontrol = 3'b010;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort_req_seen", {31'b0, found}, 32'h1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        re = 1'b0;
        #1;
        chk("abort_req_drop", {31'b0, mem_req}, 32'h0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("late_ack_req", {31'b0, mem_req}, 32'h0);
        chk("late_ack_addr", mem_addr, 32'h0);

        run_vec('{1'b1, 1'b0, 32'h00010000, 32'h00000000, 3'b010, 2, 1'b1, 32'h556680FF, 4, 1'b1, 1'b0, 32'h00010000, 3'b010});

        repeat (4) @(posedge clk);
        chk("mem_queue_empty", exp_mem.size(), 32'h0);
        chk("ret_queue_empty", exp_ret.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache controller between the CPU load/store path and the byte-addressed data memory. It accepts one load or store per cycle from the execute/memory stage and stalls the pipeline on misses and stores. It is the initiator of every data-memory transaction: word-granular fills on load misses, and byte/half/word write-throughs carrying funct3.

## Interface
- ADDRESS_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width (fixed at 32)
- SETS, 256, number of one-word lines (power of two)
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- a  in  ADDRESS_WIDTH  byte address from ALUResult
- re  in  1  load request
- we  in  1  store request (wins over re if both high)
- writedata  in  32  store data (low bytes used for sb/sh)
- memcontrol  in  3  funct3 of the load/store
- readdata  out  32  load result, sign/zero-extended per funct3
- stall  out  1  CPU must hold a/re/we/writedata/memcontrol stable while high
- mem_req  out  1  transaction valid, held until mem_ack
- mem_we  out  1  1 = write-through, 0 = word fill
- mem_addr  out  ADDRESS_WIDTH  fill: word-aligned; write: aligned per size
- mem_wdata  out  32  store data, unmodified
- mem_ctrl  out  3  funct3 for writes; 3'b010 for fills
- mem_ack  in  1  one-cycle completion pulse
- mem_rdata  in  32  fill word, valid with mem_ack; byte at base address in bits [7:0]

## Operation
- Index = a[2+log2(SETS)-1:2], tag = remaining upper bits; per line: valid bit, tag, 32-bit data.
- Alignment: half address = a & ~1, word address = a & ~3; misaligned offsets are silently forced to alignment.
- Byte lane k (a[1:0]) lives in data bits [8k+7:8k].
- Load extraction:
  - lb/lbu: lane a[1:0], sign/zero-extend.
  - lh/lhu: lanes {a[1],1} and {a[1],0}, sign/zero-extend.
  - lw: whole word.
- Unsupported memcontrol (3'b011, 3'b110, 3'b111): readdata = 32'hDEADBEEF, stall = 0, no memory transaction, no state change.
- FSM states: IDLE, FILL, WRITE.
  - IDLE, re && !we, hit: readdata valid combinationally, stall = 0, stay.
  - IDLE, re && !we, miss: stall = 1, latch word address, go FILL.
  - IDLE, we: stall = 1, latch address/writedata/memcontrol, go WRITE.
  - IDLE, neither: stall = 0, outputs idle.
  - FILL: mem_req = 1, mem_we = 0. On mem_ack: write line (data = mem_rdata, tag, valid = 1), go IDLE. stall stays 1 in the ack cycle; the load completes as a hit the following cycle.
  - WRITE: mem_req = 1, mem_we = 1. On mem_ack:
    - If the latched address hits, merge the stored bytes into the line.
    - On a miss, the line is untouched (no allocate).
    - stall = 0 in the ack cycle (store retires); go IDLE.
- mem_ack outside FILL/WRITE is ignored.

## Timing
- Reset (asynchronous, any state):
  - State IDLE.
  - All valid bits 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_ctrl = 0.
  - Tags/data are don't-care.
- Outputs combinational from inputs: stall and readdata. All mem_* outputs are registered.
- Load hit: 0-cycle latency.
- Load miss: mem_req rises the cycle after the miss is seen. Total stall = L + 2 cycles for memory ack latency L (L ≥ 1, counted from the first mem_req cycle).
- Store: stall = L + 1 cycles.
- Reset asserted mid-FILL/WRITE: the transaction is abandoned; mem_req drops immediately; a late mem_ack is ignored.
- Back-to-back: a new request presented in the cycle after the FSM returns to IDLE is accepted normally.

## Structure
- dcache_pkg:
  - state enum {IDLE, FILL, WRITE}.
  - funct3 constants: LB = 000, LH = 001, LW = 010, LBU = 100, LHU = 101, SB = 000, SH = 001, SW = 010.
  - DEADBEEF constant.
- Sub-module mem_lane_align (combinational): load extract/extend and store byte-merge; instantiated once for the read path and once for the hit-merge path.
- Tag/data/valid arrays are plain registers; valid is a flat SETS-bit vector for single-cycle reset clear.

## Test plan
- Reset, then lw 0x10000 (memory word 0x11223344, L = 3) → stall for 5 cycles, one fill with mem_addr 0x10000 and mem_ctrl 010. Next cycle readdata = 0x11223344, stall = 0. An immediate repeat lw gives no mem_req.
- After the above fill: lb 0x10003 → 0x00000011; lb 0x10000 with line 0x112233C4 → 0xFFFFFFC4; lbu → 0x000000C4; lh 0x10002 → 0x00001122; lhu/lh on lanes 0x80FF → 0x000080FF / 0xFFFF80FF.
- sb 0x10001 data 0xAB on a cached line 0x11223344 → one write with mem_ctrl 000 and mem_addr 0x10001; stall = L + 1. The following lw is a hit returning 0x1122AB44.
- sw to an uncached address 0x20000 → write-through issued; the following lw 0x20000 misses and fills (no allocate).
- Conflict: fill 0x10000, then lw 0x10400 (same index, SETS = 256) → miss and refill; lw 0x10000 misses again.
- Reset asserted during FILL before mem_ack → mem_req low asynchronously; the late mem_ack is ignored; the next lw misses (valid cleared). Also memcontrol = 011 → 0xDEADBEEF with no request.
